// File: rtl/id_ex_forward_stage.sv
// ---------------------------------------------------------------------------
// id_ex_forward_stage
//
// ID/EX pipeline register with operand-forwarding select generation and
// load-use hazard detection.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   id_valid                     decode stage holds a valid instruction
//   id_rs1/id_rs2/id_rd          source/destination register indices
//   id_rd1/id_rd2/id_imm         register read data and sign-extended immediate
//   id_reg_write/id_mem_to_reg/id_use_imm   decode control bits
//   stall                        hold the stage contents
//   flush                        replace the stage contents with a bubble
//   ex_mem_rd/mem_wb_rd          destination indices of the later stages
//   ex_mem_reg_write/mem_wb_reg_write       write enables of the later stages
//   ex_valid/ex_reg_write/ex_mem_to_reg     registered control bits
//   ex_rd1/ex_rd2/ex_imm         registered operands
//   ex_rd                        registered destination index
//   ex_sel_a/ex_sel_b            operand mux selects
//                                (00 reg, 01 EX/MEM, 10 MEM/WB, 11 immediate)
//   load_use_hazard              request to stall decode
//   stall_count/flush_count      saturating event counters
// ---------------------------------------------------------------------------
module id_ex_forward_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_use_imm,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_W-1:0]  ex_mem_rd,
    input  logic [REG_W-1:0]  mem_wb_rd,
    input  logic              ex_mem_reg_write,
    input  logic              mem_wb_reg_write,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rd,
    output logic [1:0]        ex_sel_a,
    output logic [1:0]        ex_sel_b,
    output logic              load_use_hazard,
    output logic [15:0]       stall_count,
    output logic [15:0]       flush_count
);

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              use_imm_q, use_imm_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [REG_W-1:0]  rs1_q, rs1_d;
    logic [REG_W-1:0]  rs2_q, rs2_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic [15:0]       flush_cnt_q, flush_cnt_d;

    logic capture;
    logic bubble;

    // Flush wins over stall; an invalid decode slot captured normally
    // turns into a bubble as well.
    assign capture = !flush && !stall;
    assign bubble  = flush || (capture && !id_valid);

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        use_imm_d    = use_imm_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        if (bubble) begin
            // Source indices are left as they were; with valid cleared
            // they cannot influence the selects.
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            use_imm_d    = 1'b0;
            rd1_d        = '0;
            rd2_d        = '0;
            imm_d        = '0;
            rd_d         = '0;
        end else if (capture) begin
            valid_d      = 1'b1;
            reg_write_d  = id_reg_write;
            mem_to_reg_d = id_mem_to_reg;
            use_imm_d    = id_use_imm;
            rd1_d        = id_rd1;
            rd2_d        = id_rd2;
            imm_d        = id_imm;
            rd_d         = id_rd;
            rs1_d        = id_rs1;
            rs2_d        = id_rs2;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            use_imm_q    <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            use_imm_q    <= use_imm_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Per-operand forwarding select: EX/MEM has priority over MEM/WB and
    // register 0 is never forwarded.
    logic [REG_W-1:0] rs_q [2];
    logic [1:0]       fwd_sel [2];

    assign rs_q[0] = rs1_q;
    assign rs_q[1] = rs2_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_ex_mem;
            logic hit_mem_wb;
            assign hit_ex_mem  = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs_q[gi]);
            assign hit_mem_wb  = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs_q[gi]);
            assign fwd_sel[gi] = hit_ex_mem ? 2'b01 :
                                 hit_mem_wb ? 2'b10 : 2'b00;
        end
    endgenerate

    assign ex_sel_a = !valid_q  ? 2'b00 : fwd_sel[0];
    assign ex_sel_b = !valid_q  ? 2'b00 :
                      use_imm_q ? 2'b11 : fwd_sel[1];

    // A load in EX whose destination is read by the instruction in ID.
    // rs2 is irrelevant when the ID instruction takes the immediate.
    assign load_use_hazard = valid_q && mem_to_reg_q && (rd_q != '0) && id_valid &&
                             ((rd_q == id_rs1) || ((rd_q == id_rs2) && !id_use_imm));

    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;
    assign ex_rd1        = rd1_q;
    assign ex_rd2        = rd2_q;
    assign ex_imm        = imm_q;
    assign ex_rd         = rd_q;
    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

endmodule
